// File: rtl/cache_port_arbiter_if.sv
// Signal bundle between the two CPU-side requesters, the port arbiter and the cache controller.
interface cache_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [3:0]    m0_bval, m1_bval;
    logic          m0_rd, m0_wr, m1_rd, m1_wr;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_ack, m1_ack, m0_err, m1_err;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic [3:0]    c_bval;
    logic          c_rd, c_wr;
    logic [DW-1:0] c_rdata;
    logic          c_ack;
    logic          busy, grant;

    // master is the arbiter's view; slave is the requesters plus cache controller
    modport master (
        input  m0_addr, m0_wdata, m0_bval, m0_rd, m0_wr,
        input  m1_addr, m1_wdata, m1_bval, m1_rd, m1_wr,
        output m0_rdata, m0_ack, m0_err, m1_rdata, m1_ack, m1_err,
        output c_addr, c_wdata, c_bval, c_rd, c_wr,
        input  c_rdata, c_ack,
        output busy, grant
    );
    modport slave (
        output m0_addr, m0_wdata, m0_bval, m0_rd, m0_wr,
        output m1_addr, m1_wdata, m1_bval, m1_rd, m1_wr,
        input  m0_rdata, m0_ack, m0_err, m1_rdata, m1_ack, m1_err,
        input  c_addr, c_wdata, c_bval, c_rd, c_wr,
        output c_rdata, c_ack,
        input  busy, grant
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache request port between two requesters,
// with a one-cycle command strobe, ack/data return and a no-ack watchdog.
module cache_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input logic                  sys_clk,
    input logic                  sys_rst_n,
    cache_port_arbiter_if.master bus
);
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nxt;

    logic [1:0][AW-1:0] m_addr;
    logic [1:0][DW-1:0] m_wdata;
    logic [1:0][3:0]    m_bval;
    logic [1:0]         m_wr, m_req;

    logic           gnt, last_grant, op_wr, pick, timeout_hit, err_q;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q, rdata_q;
    logic [3:0]     bval_q;
    logic [WDW-1:0] wdog;

    assign m_addr  = {bus.m1_addr, bus.m0_addr};
    assign m_wdata = {bus.m1_wdata, bus.m0_wdata};
    assign m_bval  = {bus.m1_bval, bus.m0_bval};
    assign m_wr    = {bus.m1_wr, bus.m0_wr};
    assign m_req   = {bus.m1_rd | bus.m1_wr, bus.m0_rd | bus.m0_wr};

    // On contention the requester not served last wins
    assign pick        = (m_req == 2'b11) ? ~last_grant : m_req[1];
    assign timeout_hit = (TIMEOUT != 0) && (wdog == WDW'(TIMEOUT - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (|m_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = bus.c_ack ? RESP : WAIT;
            WAIT:    if (bus.c_ack || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            op_wr      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            bval_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            wdog       <= '0;
        end else begin
            unique case (state)
                IDLE: if (|m_req) begin
                    gnt     <= pick;
                    op_wr   <= m_wr[pick];
                    addr_q  <= m_addr[pick];
                    wdata_q <= m_wdata[pick];
                    bval_q  <= m_bval[pick];
                end
                ISSUE: begin
                    wdog <= '0;
                    if (bus.c_ack) begin
                        rdata_q <= bus.c_rdata;
                        err_q   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.c_ack) begin
                        rdata_q <= bus.c_rdata;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else if (wdog != '1) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP:    last_grant <= gnt;
                default: ;
            endcase
        end
    end

    // Response fields are gated so the idle requester always sees zeros
    always_comb begin
        bus.c_rd     = (state == ISSUE) && !op_wr;
        bus.c_wr     = (state == ISSUE) && op_wr;
        bus.busy     = (state != IDLE);
        bus.m0_ack   = (state == RESP) && !gnt;
        bus.m1_ack   = (state == RESP) && gnt;
        bus.m0_rdata = bus.m0_ack ? rdata_q : '0;
        bus.m1_rdata = bus.m1_ack ? rdata_q : '0;
        bus.m0_err   = bus.m0_ack && err_q;
        bus.m1_err   = bus.m1_ack && err_q;
    end

    assign bus.c_addr  = addr_q;
    assign bus.c_wdata = wdata_q;
    assign bus.c_bval  = bval_q;
    assign bus.grant   = gnt;
endmodule
